// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit for mult/multu/div/divu/mthi/mtlo.
// Results are computed on acceptance and held pending until the latency counter expires.
module mult_div_unit #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_phi;
  logic [31:0]        r_plo;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_isMul;
  logic               w_isDiv;
  logic               w_mulSigned;
  logic [63:0]        w_mulA;
  logic [63:0]        w_mulB;
  logic [63:0]        w_prod;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [31:0]        w_aMag;
  logic [31:0]        w_bMag;
  logic [31:0]        w_qMag;
  logic [31:0]        w_rMag;
  logic [31:0]        w_divHi;
  logic [31:0]        w_divLo;

  assign w_isMul     = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
  assign w_isDiv     = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
  assign w_mulSigned = (mdOp == OP_MULT);

  // Sign-extending to 64 bits lets one multiplier serve both mult and multu.
  assign w_mulA = {{32{w_mulSigned & reg1[31]}}, reg1};
  assign w_mulB = {{32{w_mulSigned & reg2[31]}}, reg2};
  assign w_prod = w_mulA * w_mulB;

  // Signed divide works on magnitudes; 0x80000000 / -1 then falls out as 0x80000000 rem 0.
  assign w_aNeg = (mdOp == OP_DIV) & reg1[31];
  assign w_bNeg = (mdOp == OP_DIV) & reg2[31];
  assign w_aMag = w_aNeg ? -reg1 : reg1;
  assign w_bMag = w_bNeg ? -reg2 : reg2;
  assign w_qMag = w_aMag / w_bMag;
  assign w_rMag = w_aMag % w_bMag;

  always_comb begin
    w_divHi = w_aNeg ? -w_rMag : w_rMag;
    w_divLo = (w_aNeg ^ w_bNeg) ? -w_qMag : w_qMag;
    if (reg2 == 32'd0) begin
      w_divHi = reg1;
      w_divLo = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_isMul)      w_nextState = S_MUL;
        else if (start && w_isDiv) w_nextState = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (r_cnt == '0) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_phi <= '0;
      r_plo <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        case (mdOp)
          OP_MULT, OP_MULTU: begin
            r_phi <= w_prod[63:32];
            r_plo <= w_prod[31:0];
            r_cnt <= CNT_W'(MUL_LAT - 1);
          end
          OP_DIV, OP_DIVU: begin
            r_phi <= w_divHi;
            r_plo <= w_divLo;
            r_cnt <= CNT_W'(DIV_LAT - 1);
          end
          OP_MTHI: r_hi <= reg1;
          OP_MTLO: r_lo <= reg1;
          default: ;
        endcase
      end
    end else if (r_cnt == '0) begin
      r_hi <= r_phi;
      r_lo <= r_plo;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases pinned to literals,
// then randomized traffic compared every cycle against an arithmetic model.
module tb_mult_div_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdOp = 3'd0;
  logic [31:0] reg1 = 32'd0;
  logic [31:0] reg2 = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int nChecks = 0;
  int nErrors = 0;

  // Model state: architectural HI/LO, the pending result and remaining busy cycles.
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [31:0] mPendHi = 32'd0;
  logic [31:0] mPendLo = 32'd0;
  int          mLeft = 0;

  mult_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdOp(mdOp),
    .reg1(reg1), .reg2(reg2), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void calcResult(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] rHi,
                                     output logic [31:0] rLo);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sRes;
    longint          sRem;
    longint unsigned uRes;
    longint unsigned uRem;
    rHi = 32'd0;
    rLo = 32'd0;
    case (op)
      3'd0: begin sRes = sa * sb; rHi = sRes[63:32]; rLo = sRes[31:0]; end
      3'd1: begin uRes = ua * ub; rHi = uRes[63:32]; rLo = uRes[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin rHi = a; rLo = 32'hFFFF_FFFF; end
        else begin sRes = sa / sb; sRem = sa % sb; rHi = sRem[31:0]; rLo = sRes[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) begin rHi = a; rLo = 32'hFFFF_FFFF; end
        else begin uRes = ua / ub; uRem = ua % ub; rHi = uRem[31:0]; rLo = uRes[31:0]; end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHi = 32'd0; mLo = 32'd0; mLeft = 0;
    end else if (mLeft > 0) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin mHi = mPendHi; mLo = mPendLo; end
    end else if (start) begin
      if (mdOp <= 3'd3) begin
        calcResult(mdOp, reg1, reg2, mPendHi, mPendLo);
        mLeft = (mdOp <= 3'd1) ? MUL_LAT : DIV_LAT;
      end else if (mdOp == 3'd4) begin
        mHi = reg1;
      end else if (mdOp == 3'd5) begin
        mLo = reg1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("busy", {31'd0, busy}, {31'd0, (mLeft > 0)});
    checkOutput("hi", hi, mHi);
    checkOutput("lo", lo, mLo);
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    start = 1'b1; mdOp = op; reg1 = a; reg2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (busy) checkOutput("idleTimeout", 32'd1, 32'd0);
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input int expCycles);
    int n;
    applyStimulus(op, a, b);
    waitIdle(n);
    checkOutput({name, "Cycles"}, n, expCycles);
    checkOutput({name, "Hi"}, hi, expHi);
    checkOutput({name, "Lo"}, lo, expLo);
    checkOutput({name, "ModelHi"}, mHi, expHi);
    checkOutput({name, "ModelLo"}, mLo, expLo);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetHi", hi, 32'd0);
    checkOutput("resetLo", lo, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mult -2*3: HI/LO must hold 0 for the whole busy window.
    applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3);
    n = 0;
    while (busy && n < 50) begin
      checkOutput("mulHoldHi", hi, 32'd0);
      checkOutput("mulHoldLo", lo, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mulCycles", n, 32'd5);
    checkOutput("mulHi", hi, 32'hFFFF_FFFF);
    checkOutput("mulLo", lo, 32'hFFFF_FFFA);

    runOp("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    runOp("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    runOp("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 10);
    runOp("divByZero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10);
    runOp("divOvf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

    applyStimulus(3'd4, 32'h1234_5678, 32'd0);
    checkOutput("mthiHi", hi, 32'h1234_5678);
    checkOutput("mthiBusy", {31'd0, busy}, 32'd0);
    applyStimulus(3'd5, 32'hCAFE_0001, 32'd0);
    checkOutput("mtloLo", lo, 32'hCAFE_0001);
    checkOutput("mtloBusy", {31'd0, busy}, 32'd0);

    // mtlo while a mult is in flight must vanish.
    applyStimulus(3'd0, 32'd100, 32'd200);
    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'd0);
    waitIdle(n);
    checkOutput("ignoredLo", lo, 32'd20000);
    checkOutput("ignoredHi", hi, 32'd0);

    // Reset in cycle 3 of a div, then confirm no stale write after release.
    applyStimulus(3'd2, 32'd1000, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortHi", hi, 32'd0);
    checkOutput("abortLo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("staleHi", hi, 32'd0);
    checkOutput("staleLo", lo, 32'd0);
    runOp("mul6x7", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);

    // Random traffic, including reserved ops and starts while busy.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      mdOp  = 3'($urandom_range(0, 7));
      reg1  = randOperand();
      reg2  = randOperand();
      @(posedge clk); #1;
    end
    start = 1'b0;
    waitIdle(n);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
